// File: rtl/lampfpu_tay_round_pack.sv
// ============================================================================
//  Module   : lampfpu_tay_round_pack
//  Purpose  : Round-to-nearest-even and bfloat16 packing for the Taylor-path
//             add/sub result, followed by an output FIFO with valid/ready
//             handshake, sticky IEEE exception flags and credit-style
//             issue throttling (ready_o) toward the non-stallable add/sub.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             valid_i, s_i, e_i, f_i, isOverflow_i, isUnderflow_i,
//             isToRound_i         - post-normalised add/sub result
//             ready_o             - upstream may issue another operation
//             valid_o, ready_i    - FIFO head handshake
//             res_o, flags_o      - head entry {s,e,frac} and {OF,UF,NX}
//             clr_flags_i         - clear sticky flags
//             sticky_flags_o      - accumulated {OF,UF,NX}
//             drop_err_o          - sticky: a result was lost on a full FIFO
//  Options  : LAMP_TAY_RND_FTZ_EN - flush rounded denormals to signed zero
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lampfpu_tay_round_pack #(
    parameter int E_DW  = 8,
    parameter int F_DW  = 7,
    parameter int DEPTH = 8,
    parameter int SKID  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 s_i,
    input  logic [E_DW-1:0]      e_i,
    input  logic [F_DW+4:0]      f_i,
    input  logic                 isOverflow_i,
    input  logic                 isUnderflow_i,
    input  logic                 isToRound_i,
    output logic                 ready_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [E_DW+F_DW:0]   res_o,
    output logic [2:0]           flags_o,
    input  logic                 clr_flags_i,
    output logic [2:0]           sticky_flags_o,
    output logic                 drop_err_o
);

    localparam int c_RW = 1 + E_DW + F_DW;   // packed result width
    localparam int c_EW = c_RW + 3;          // FIFO entry: {res, flags}
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_USED_MAX  = c_CW'(DEPTH - SKID);

    // ---------------------------------------------------------------- round
    logic                   w_lsb;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_up;
    logic [E_DW+F_DW-1:0]   w_sum;
    logic [E_DW-1:0]        w_eRnd;
    logic [F_DW-1:0]        w_fRnd;

    assign w_lsb    = f_i[3];
    assign w_guard  = f_i[2];
    assign w_sticky = f_i[1] | f_i[0];
    assign w_up     = w_guard & (w_lsb | w_sticky);

    // Exponent and fraction are added as one word so a fraction carry bumps
    // the exponent (denormal -> normal, all-ones fraction -> e+1) for free.
    assign w_sum  = {e_i, f_i[F_DW+2:3]} + (E_DW+F_DW)'(w_up);
    assign w_eRnd = w_sum[E_DW+F_DW-1:F_DW];
    assign w_fRnd = w_sum[F_DW-1:0];

    logic [E_DW-1:0] w_s1E;
    logic [F_DW-1:0] w_s1F;
    logic            w_of;
    logic            w_uf;
    logic            w_nx;

    always_comb begin
        // Bypass path: special-value fraction sits at the top of f_i.
        w_s1E = e_i;
        w_s1F = f_i[F_DW+4:5];
        w_of  = isOverflow_i;
        w_uf  = isUnderflow_i;
        w_nx  = 1'b0;
        if (isToRound_i) begin
            w_s1E = w_eRnd;
            w_s1F = w_fRnd;
            w_nx  = w_guard | w_sticky;
            if (isOverflow_i || (&w_eRnd)) begin
                w_s1E = '1;
                w_s1F = '0;
                w_of  = 1'b1;
                w_nx  = 1'b1;
            end
`ifdef LAMP_TAY_RND_FTZ_EN
            else if ((w_eRnd == '0) && (w_fRnd != '0)) begin
                w_s1F = '0;
                w_uf  = 1'b1;
                w_nx  = 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------- stage 1
    logic            r_s1Valid;
    logic [c_EW-1:0] r_s1Entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Entry <= '0;
        end else begin
            r_s1Valid <= valid_i;
            r_s1Entry <= {s_i, w_s1E, w_s1F, w_of, w_uf, w_nx};
        end
    end

    // ----------------------------------------------------------------- FIFO
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_wrPtr;
    logic [c_PW-1:0] r_rdPtr;
    logic [c_CW-1:0] r_count;
    logic [2:0]      r_sticky;
    logic            r_dropErr;

    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic [c_CW-1:0] w_used;
    logic [c_EW-1:0] w_head;

    assign w_full = (r_count == c_DEPTH_CNT);
    assign w_pop  = valid_o & ready_i;
    // At full, the slot freed by a same-cycle pop is reused.
    assign w_push = r_s1Valid & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_s1Entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_sticky  <= '0;
            r_dropErr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (r_s1Valid && !w_push) begin
                r_dropErr <= 1'b1;
            end
            // A flag arriving with the clear survives it.
            if (clr_flags_i) begin
                r_sticky <= w_push ? r_s1Entry[2:0] : 3'b000;
            end else if (w_push) begin
                r_sticky <= r_sticky | r_s1Entry[2:0];
            end
        end
    end

    // Slots still uncommitted after counting the op sitting in stage 1.
    assign w_used = r_count + c_CW'(r_s1Valid);
    assign ready_o = (w_used <= c_USED_MAX);

    assign valid_o        = (r_count != '0);
    assign w_head         = r_mem[r_rdPtr];
    // Gate the head so outputs read zero while the FIFO is empty/unwritten.
    assign res_o          = valid_o ? w_head[c_EW-1:3] : '0;
    assign flags_o        = valid_o ? w_head[2:0] : 3'b000;
    assign sticky_flags_o = r_sticky;
    assign drop_err_o     = r_dropErr;

endmodule

`default_nettype wire

// File: tb/tb_lampfpu_tay_round_pack.sv
// ============================================================================
//  Module   : tb_lampfpu_tay_round_pack
//  Purpose  : Directed self-checking bench for lampfpu_tay_round_pack.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lampfpu_tay_round_pack;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        s_i;
    logic [7:0]  e_i;
    logic [11:0] f_i;
    logic        isOverflow_i;
    logic        isUnderflow_i;
    logic        isToRound_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] res_o;
    logic [2:0]  flags_o;
    logic        clr_flags_i;
    logic [2:0]  sticky_flags_o;
    logic        drop_err_o;

    int errors = 0;
    int checks = 0;

    lampfpu_tay_round_pack dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .s_i            (s_i),
        .e_i            (e_i),
        .f_i            (f_i),
        .isOverflow_i   (isOverflow_i),
        .isUnderflow_i  (isUnderflow_i),
        .isToRound_i    (isToRound_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .res_o          (res_o),
        .flags_o        (flags_o),
        .clr_flags_i    (clr_flags_i),
        .sticky_flags_o (sticky_flags_o),
        .drop_err_o     (drop_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] e, input logic [11:0] f,
                         input logic toRound, input logic unf);
        valid_i       = 1'b1;
        s_i           = 1'b0;
        e_i           = e;
        f_i           = f;
        isToRound_i   = toRound;
        isOverflow_i  = 1'b0;
        isUnderflow_i = unf;
    endtask

    // One operation through an empty FIFO with ready_i=1: check latency,
    // result and flags, then let it pop.
    task automatic single(input string tag, input logic [7:0] e, input logic [11:0] f,
                          input logic toRound, input logic unf,
                          input logic [15:0] expRes, input logic [2:0] expFlags);
        drive(e, f, toRound, unf);
        step();
        valid_i = 1'b0;
        chk({tag, "_lat1"}, 16'(valid_o), 16'h0);
        step();
        chk({tag, "_valid"}, 16'(valid_o), 16'h1);
        chk({tag, "_res"}, res_o, expRes);
        chk({tag, "_flags"}, 16'(flags_o), 16'(expFlags));
        step();
    endtask

    task automatic clearFlags();
        clr_flags_i = 1'b1;
        step();
        clr_flags_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; s_i = 1'b0; e_i = '0; f_i = '0;
        isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b0;
        ready_i = 1'b1; clr_flags_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 16'(valid_o), 16'h0);
        chk("rst_res", res_o, 16'h0);
        chk("rst_flags", 16'(flags_o), 16'h0);
        chk("rst_sticky", 16'(sticky_flags_o), 16'h0);
        chk("rst_drop", 16'(drop_err_o), 16'h0);
        chk("rst_ready", 16'(ready_o), 16'h1);

        single("tieEven", 8'h7F, 12'b0_1_0000000_100, 1'b1, 1'b0, 16'h3F80, 3'b001);
        chk("tieEven_sticky", 16'(sticky_flags_o), 16'h1);
        clearFlags();
        chk("clr1_sticky", 16'(sticky_flags_o), 16'h0);

        single("roundUp", 8'h7F, 12'b0_1_0000001_100, 1'b1, 1'b0, 16'h3F82, 3'b001);
        single("carry",   8'h7F, 12'b0_1_1111111_101, 1'b1, 1'b0, 16'h4000, 3'b001);
        single("exact",   8'h80, 12'b0_1_0101010_000, 1'b1, 1'b0, 16'h402A, 3'b000);
        clearFlags();

        single("ovf", 8'hFE, 12'b0_1_1111111_110, 1'b1, 1'b0, 16'h7F80, 3'b101);
        chk("ovf_sticky", 16'(sticky_flags_o), 16'h5);
        step();
        chk("ovf_sticky_hold", 16'(sticky_flags_o), 16'h5);
        clearFlags();
        chk("clr2_sticky", 16'(sticky_flags_o), 16'h0);

        single("nan", 8'hFF, 12'b1000000_00000, 1'b0, 1'b0, 16'h7FC0, 3'b000);
`ifdef LAMP_TAY_RND_FTZ_EN
        single("denorm", 8'h00, 12'b0_0_0000011_000, 1'b1, 1'b0, 16'h0000, 3'b011);
`else
        single("denorm", 8'h00, 12'b0_0_0000011_000, 1'b1, 1'b1, 16'h0003, 3'b010);
`endif

        // Reset while an op sits in stage 1 discards it.
        drive(8'h7F, 12'b0_1_0000000_000, 1'b1, 1'b0);
        step();
        valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midRst_valid", 16'(valid_o), 16'h0);
        chk("midRst_sticky", 16'(sticky_flags_o), 16'h0);

        // Backpressure: fill the FIFO with ready_i low.
        ready_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive(8'h7F, {2'b01, 7'(k), 3'b000}, 1'b1, 1'b0);
            step();
            if (k == 5) chk("bp_ready5", 16'(ready_o), 16'h1);
            if (k == 6) chk("bp_ready6", 16'(ready_o), 16'h0);
        end
        valid_i = 1'b0;
        step();
        chk("full_valid", 16'(valid_o), 16'h1);
        chk("full_head", res_o, 16'h3F81);

        // Push at full with a same-cycle pop is accepted.
        drive(8'h7F, {2'b01, 7'd9, 3'b000}, 1'b1, 1'b0);
        step();
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("pushPop_drop", 16'(drop_err_o), 16'h0);
        chk("pushPop_head", res_o, 16'h3F82);

        // Push at full without a pop is dropped.
        drive(8'h7F, {2'b01, 7'd10, 3'b000}, 1'b1, 1'b0);
        step();
        valid_i = 1'b0;
        step();
        chk("drop_err", 16'(drop_err_o), 16'h1);

        ready_i = 1'b1;
        for (int j = 2; j <= 9; j++) begin
            chk($sformatf("drain%0d_valid", j), 16'(valid_o), 16'h1);
            chk($sformatf("drain%0d_res", j), res_o, 16'h3F80 + 16'(j));
            step();
        end
        chk("drained_valid", 16'(valid_o), 16'h0);
        chk("drained_ready", 16'(ready_o), 16'h1);
        chk("drained_drop", 16'(drop_err_o), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
